// File: rtl/sequence_generator.sv
// Sequence generator: fills a DEPTH-entry digit memory from a 16-bit Galois LFSR on GoGen and serves reads with 2-cycle latency.
// Optional SEQGEN_SEED_LOAD_EN adds SeedLoad/SeedIn to reseed the LFSR at run time.
module sequence_generator #(
  parameter int          DEPTH      = 32,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          MAX_REJECT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        GoGen,
  input  logic [3:0]  Diff,
  input  logic [4:0]  SeqAddr,
`ifdef SEQGEN_SEED_LOAD_EN
  input  logic        SeedLoad,
  input  logic [15:0] SeedIn,
`endif
  output logic [3:0]  RAMOutput,
  output logic        FinGen
);

  localparam logic [15:0] SeedSafe = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LfsrMask = 16'hB400;
  localparam int          RejW     = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;
  localparam logic [RejW-1:0] RejLast = RejW'(MAX_REJECT - 1);
  localparam logic [4:0]  LastAddr = 5'(DEPTH - 1);
  localparam logic [5:0]  DepthLim = 6'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t          stateReg, stateNext;
  logic [4:0]      fillAddrReg, fillAddrNext;
  logic [RejW-1:0] rejCntReg, rejCntNext;
  logic [3:0]      diffEffReg, diffEffNext;
  logic [15:0]     lfsrReg, lfsrNext;
  logic [4:0]      readAddrReg;
  logic            memWe;
  logic [3:0]      memWData;
  logic [3:0]      candidate;

  logic [3:0] mem [DEPTH];

  assign candidate = lfsrReg[3:0];
  assign lfsrNext  = lfsrReg[0] ? ((lfsrReg >> 1) ^ LfsrMask) : (lfsrReg >> 1);

  // The LFSR free-runs in every state so the moment GoGen arrives perturbs the sequence.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lfsrReg <= SeedSafe;
    end else begin
`ifdef SEQGEN_SEED_LOAD_EN
      if (SeedLoad) begin
        lfsrReg <= (SeedIn == 16'h0000) ? 16'hACE1 : SeedIn;
      end else begin
        lfsrReg <= lfsrNext;
      end
`else
      lfsrReg <= lfsrNext;
`endif
    end
  end

  always_comb begin
    stateNext    = stateReg;
    fillAddrNext = fillAddrReg;
    rejCntNext   = rejCntReg;
    diffEffNext  = diffEffReg;
    memWe        = 1'b0;
    memWData     = 4'd0;
    if (GoGen) begin
      stateNext    = FILL;
      fillAddrNext = 5'd0;
      rejCntNext   = '0;
      diffEffNext  = (Diff == 4'd0) ? 4'd1 : Diff;
    end else if (stateReg == FILL) begin
      if (candidate <= diffEffReg) begin
        memWe    = 1'b1;
        memWData = candidate;
      end else if (rejCntReg == RejLast) begin
        // Too many misses in a row: store a 0 so the fill time stays bounded.
        memWe    = 1'b1;
        memWData = 4'd0;
      end else begin
        rejCntNext = rejCntReg + 1'b1;
      end
      if (memWe) begin
        rejCntNext   = '0;
        fillAddrNext = fillAddrReg + 5'd1;
        if (fillAddrReg == LastAddr) begin
          stateNext = DONE;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stateReg    <= IDLE;
      fillAddrReg <= 5'd0;
      rejCntReg   <= '0;
      diffEffReg  <= 4'd1;
      FinGen      <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      fillAddrReg <= fillAddrNext;
      rejCntReg   <= rejCntNext;
      diffEffReg  <= diffEffNext;
      FinGen      <= (stateReg == DONE) && !GoGen;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (memWe) begin
      mem[fillAddrReg] <= memWData;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      readAddrReg <= 5'd0;
      RAMOutput   <= 4'd0;
    end else begin
      readAddrReg <= SeqAddr;
      RAMOutput   <= ({1'b0, readAddrReg} < DepthLim) ? mem[readAddrReg] : 4'd0;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Randomized self-checking bench for sequence_generator against a cycle-level behavioural model.
module tb_sequence_generator;

  localparam int DEPTH = 32;
  localparam int MAXR  = 15;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       GoGen = 1'b0;
  logic [3:0] Diff = 4'd0;
  logic [4:0] SeqAddr = 5'd0;
  logic [3:0] RAMOutput;
  logic       FinGen;

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  sequence_generator #(.DEPTH(DEPTH), .SEED(16'hACE1), .MAX_REJECT(MAXR)) dut (
    .Clk(Clk), .Rst(Rst), .GoGen(GoGen), .Diff(Diff), .SeqAddr(SeqAddr),
    .RAMOutput(RAMOutput), .FinGen(FinGen)
  );

  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  logic [15:0] mLfsr = 16'hACE1;
  logic [3:0]  mMem [DEPTH];
  bit          mValid [DEPTH];
  bit          mFilling = 0, mDone = 0;
  int          mAddr = 0, mRej = 0, fallbacks = 0;
  logic [3:0]  mDiff = 4'd1;
  logic [4:0]  mRdAddr = 5'd0;
  logic        expFin = 1'b0;
  logic [3:0]  expOut = 4'd0;
  bit          expOutValid = 1'b1;

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge Clk or negedge Rst) begin
    logic [3:0] cand;
    if (!Rst) begin
      mLfsr = 16'hACE1; mFilling = 0; mDone = 0; mAddr = 0; mRej = 0;
      mRdAddr = 5'd0; expFin = 1'b0; expOut = 4'd0; expOutValid = 1'b1;
    end else begin
      expOutValid = mValid[mRdAddr];
      expOut      = mMem[mRdAddr];
      mRdAddr     = SeqAddr;
      expFin      = mDone && !GoGen;
      cand        = mLfsr[3:0];
      if (GoGen) begin
        mFilling = 1; mDone = 0; mAddr = 0; mRej = 0;
        mDiff = (Diff == 4'd0) ? 4'd1 : Diff;
      end else if (mFilling) begin
        if (cand <= mDiff) begin
          mMem[mAddr] = cand; mValid[mAddr] = 1; mAddr++; mRej = 0;
        end else begin
          mRej++;
          if (mRej == MAXR) begin
            mMem[mAddr] = 4'd0; mValid[mAddr] = 1; mAddr++; mRej = 0; fallbacks++;
          end
        end
        if (mAddr == DEPTH) begin
          mFilling = 0; mDone = 1;
        end
      end
      mLfsr = lfsrStep(mLfsr);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge Clk) begin
    if (checkEn) begin
      check("cyc_FinGen", FinGen, expFin);
      if (expOutValid) check("cyc_RAMOutput", RAMOutput, expOut);
    end
  end

  task automatic readMem(input logic [4:0] a, output logic [3:0] d);
    SeqAddr = a;
    @(negedge Clk);
    @(negedge Clk);
    d = RAMOutput;
  endtask

  task automatic pulseGo(input logic [3:0] dv);
    Diff = dv; GoGen = 1'b1;
    @(negedge Clk);
    GoGen = 1'b0;
  endtask

  task automatic waitFin(input string name, input int budget, output int cnt);
    cnt = 0;
    while (!FinGen && cnt < budget) begin
      @(negedge Clk);
      cnt++;
    end
    check(name, FinGen, 1);
  endtask

  task automatic readAll(input string name, input int bound);
    logic [3:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      readMem(5'(i), d);
      check(name, d, mMem[i]);
      check({name, "_bound"}, int'(d) <= bound, 1);
    end
  endtask

  task automatic fullRangePins(input string tag);
    logic [3:0] d;
    int cnt;
    repeat (5) @(negedge Clk);
    pulseGo(4'd15);
    waitFin({tag, "_fin"}, 60, cnt);
    check({tag, "_fin_edges"}, cnt, 33);
    readMem(5'd0, d); check({tag, "_mem0"}, d, 3);
    readMem(5'd1, d); check({tag, "_mem1"}, d, 9);
    readMem(5'd2, d); check({tag, "_mem2"}, d, 4);
    readAll({tag, "_all"}, 15);
    $display("[TB] %s fill: FinGen after %0d edges", tag, cnt);
  endtask

  initial begin
    logic [3:0] d;
    int cnt;

    check("pin_step1", lfsrStep(16'hACE1), 16'hE270);
    check("pin_step6", lfsrStep(lfsrStep(lfsrStep(lfsrStep(lfsrStep(lfsrStep(16'hACE1)))))), 16'hB313);

    repeat (3) @(negedge Clk);
    check("reset_FinGen", FinGen, 0);
    check("reset_RAMOutput", RAMOutput, 0);
    Rst = 1'b1;
    checkEn = 1'b1;

    fullRangePins("first");

    pulseGo(4'd3);
    waitFin("diff3_fin", 600, cnt);
    readAll("diff3", 3);
    $display("[TB] diff=3 fill: %0d cycles", cnt);

    pulseGo(4'd0);
    waitFin("diff0_fin", 600, cnt);
    readAll("diff0", 1);
    $display("[TB] diff=0 fill: %0d cycles, fallbacks so far %0d", cnt, fallbacks);

    pulseGo(4'd15);
    repeat (9) @(negedge Clk);
    check("restart_midfill_fin", FinGen, 0);
    pulseGo(4'd7);
    waitFin("restart_fin", 600, cnt);
    readAll("restart", 7);
    $display("[TB] restart fill: %0d cycles", cnt);

    SeqAddr = 5'd5;
    @(negedge Clk);
    SeqAddr = 5'd6;
    @(negedge Clk);
    check("lat_mem5", RAMOutput, mMem[5]);
    @(negedge Clk);
    check("lat_mem6", RAMOutput, mMem[6]);
    readMem(5'd31, d);
    check("lat_mem31", d, mMem[31]);
    $display("[TB] latency reads done");

    for (int it = 0; it < 8; it++) begin
      int restarts;
      logic [3:0] dv;
      restarts = 2;
      repeat ($urandom_range(0, 20)) begin
        SeqAddr = 5'($urandom_range(0, 31));
        @(negedge Clk);
      end
      dv = 4'($urandom_range(0, 15));
      pulseGo(dv);
      cnt = 0;
      while (!FinGen && cnt < 1200) begin
        SeqAddr = 5'($urandom_range(0, 31));
        if (restarts > 0 && $urandom_range(0, 99) < 3) begin
          dv = 4'($urandom_range(0, 15));
          Diff = dv; GoGen = 1'b1; restarts--;
        end else begin
          GoGen = 1'b0;
        end
        @(negedge Clk);
        cnt++;
      end
      GoGen = 1'b0;
      check("rand_fin", FinGen, 1);
      readAll("rand", (dv == 0) ? 1 : int'(dv));
      $display("[TB] random fill %0d: diff=%0d cycles=%0d", it, dv, cnt);
    end

    SeqAddr = 5'd0;
    pulseGo(4'd15);
    repeat (12) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("async_rst_FinGen", FinGen, 0);
    check("async_rst_RAMOutput", RAMOutput, 0);
    repeat (3) @(negedge Clk);
    check("rst_hold_FinGen", FinGen, 0);
    #2 Rst = 1'b1;
    $display("[TB] mid-fill reset released");
    fullRangePins("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
